fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core. Holds the program counter, issues word requests to instruction memory over a valid/ready request channel and an in-order response channel, and buffers the returned words with their PCs in a 2-entry queue. The queue drives the decode stage over a valid/ready handshake. Branch and jump redirects from execute flush all stale fetches.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the fetch and decode stages.
package rv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0, x0, 0

    // Major opcodes (inst[6:0]) of the RV32I base ISA.
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b000_0011,
        OPC_OP_IMM = 7'b001_0011,
        OPC_AUIPC  = 7'b001_0111,
        OPC_STORE  = 7'b010_0011,
        OPC_OP     = 7'b011_0011,
        OPC_LUI    = 7'b011_0111,
        OPC_BRANCH = 7'b110_0011,
        OPC_JALR   = 7'b110_0111,
        OPC_JAL    = 7'b110_1111,
        OPC_SYSTEM = 7'b111_0011
    } rv_opcode_e;

    // One instruction-buffer entry: the fetched word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits of an address so it points at a whole word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO. Entry 0 is always the head, so the read data
// comes straight from a register. Pops on an empty FIFO and pushes on a full
// FIFO without a same-cycle pop are ignored; flush empties it and wins over
// push and pop.
module fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Next-state: shift toward slot 0 on pop, write the first free slot on push.
    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        count_d   = count_q;
        pop_ok_s  = pop_i & (count_q != 2'd0);
        push_ok_s = push_i & ((count_q != 2'd2) | pop_ok_s);
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_d = data_i;
                    end else begin
                        slot1_d = data_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_d = data_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = data_i;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign data_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: program counter, credit-limited request issue,
// in-order response matching via a PC queue, and a 2-entry instruction buffer
// feeding decode. Redirects flush the buffer and discard in-flight responses.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    localparam logic [2:0] CREDITS = 3'(DEPTH);

    logic [31:0]  pc_q, pc_d;
    logic [1:0]   drop_q, drop_d;

    // The PC queue holds exactly one entry per accepted, unanswered request,
    // so its occupancy is the outstanding-request count.
    logic [1:0]   outstanding_s;
    logic [1:0]   occupancy_s;
    logic [31:0]  pcq_head_s;
    fetch_entry_t ibuf_in_s;
    fetch_entry_t ibuf_head_s;

    logic         id_valid_s;
    logic         id_pop_s;
    logic [2:0]   credit_s;
    logic         req_valid_s;
    logic         fire_s;
    logic         drop_resp_s;
    logic         ibuf_push_s;
    logic         ibuf_pop_s;

    assign id_valid_s  = (occupancy_s != 2'd0);
    assign id_pop_s    = id_valid_s & id_ready;
    // Slots still needed by words in flight or buffered, after this cycle's pop.
    assign credit_s    = {1'b0, outstanding_s} + {1'b0, occupancy_s} - {2'b00, id_pop_s};
    assign req_valid_s = rst_n & ~redirect_valid & (credit_s < CREDITS);
    assign fire_s      = req_valid_s & imem_req_ready;
    assign drop_resp_s = imem_resp_valid & (drop_q != 2'd0);
    assign ibuf_push_s = imem_resp_valid & (drop_q == 2'd0) & ~redirect_valid;
    assign ibuf_pop_s  = id_pop_s & ~redirect_valid;
    assign ibuf_in_s   = '{pc: pcq_head_s, inst: imem_resp_data};

    fetch_fifo #(.WIDTH(XLEN)) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fire_s),
        .data_i  (pc_q),
        .pop_i   (imem_resp_valid),
        .flush_i (1'b0),
        .data_o  (pcq_head_s),
        .count_o (outstanding_s)
    );

    fetch_fifo #(.WIDTH(2 * XLEN)) u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ibuf_push_s),
        .data_i  (ibuf_in_s),
        .pop_i   (ibuf_pop_s),
        .flush_i (redirect_valid),
        .data_o  (ibuf_head_s),
        .count_o (occupancy_s)
    );

    // PC and drop-count next state; a redirect re-targets the PC and marks
    // every response still owed by memory (minus one arriving now) as stale.
    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            drop_d = outstanding_s - {1'b0, imem_resp_valid};
        end else begin
            if (fire_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            if (drop_resp_s) begin
                drop_d = drop_q - 2'd1;
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // PC and drop-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            drop_q <= 2'd0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q;
    assign id_valid       = id_valid_s;
    assign id_inst        = id_valid_s ? ibuf_head_s.inst : NOP_INST;
    assign id_pc          = id_valid_s ? ibuf_head_s.pc : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a vector table for the reset/streaming/back-pressure
// cases, hand sequences for stall, redirect and wrap, then randomized traffic
// checked against a program-order model of the fetch and decode streams.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int total = 0;
    int bad   = 0;

    logic [31:0] memq[$];   // addresses accepted by the memory model, oldest first

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_inst         (id_inst),
        .id_pc           (id_pc)
    );

    typedef struct {
        bit          rst_before;
        bit          redir;
        logic [31:0] rpc;
        bit          rdy;
        bit          resp_en;
        bit          idr;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_idv;
        logic [31:0] e_idpc;
    } vec_t;

    // Contents of instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic vec_t mkv(input bit rb, input bit redir, input logic [31:0] rpc,
                                 input bit rdy, input bit re, input bit idr,
                                 input bit erv, input logic [31:0] ea,
                                 input bit eidv, input logic [31:0] epc);
        vec_t v;
        v.rst_before = rb;  v.redir = redir; v.rpc = rpc;
        v.rdy = rdy;        v.resp_en = re;  v.idr = idr;
        v.e_rv = erv;       v.e_addr = ea;   v.e_idv = eidv; v.e_idpc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit erv, input logic [31:0] ea,
                                 input bit eidv, input logic [31:0] epc);
        logic [31:0] einst;
        logic [31:0] eid;
        einst = eidv ? memw(epc) : 32'h0000_0013;
        eid   = eidv ? epc : 32'h0000_0000;
        check({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, erv});
        check({tag, ".req_addr"},  imem_req_addr, ea);
        check({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, eidv});
        check({tag, ".id_pc"},     id_pc, eid);
        check({tag, ".id_inst"},   id_inst, einst);
    endtask

    // Asserts reset mid-flight, checks that state clears at once, releases
    // it just after a rising edge so the next cycle is the first one out of reset.
    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        id_ready        = 1'b1;
        memq.delete();
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs after the falling edge, let outputs settle,
    // and let the memory model answer/accept according to what it sees.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy,
                        input bit resp_en, input bit idr);
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        id_ready       = idr;
        if (resp_en && memq.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memw(memq[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
        #1;
        if (imem_resp_valid) void'(memq.pop_front());
        if (imem_req_valid && imem_req_ready) memq.push_back(imem_req_addr);
    endtask

    initial begin
        vec_t        vt[$];
        logic [31:0] model_fetch;
        logic [31:0] exp_id;
        logic [31:0] prev_addr;
        bit          prev_valid;
        bit          prev_fire;
        bit          prev_redir;
        bit          redir;
        bit          rdy;
        bit          re;
        bit          idr;
        logic [31:0] rpc;
        int          pops;

        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        id_ready        = 1'b1;

        // Streaming out of reset with a 1-cycle memory and decode always ready.
        vt.push_back(mkv(1, 0, 0, 1, 1, 1,  1, 32'h00, 0, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h04, 0, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h08, 1, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h0C, 1, 32'h4));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h10, 1, 32'h8));
        // Decode stalled for 6 cycles: two requests, then issue stops.
        vt.push_back(mkv(1, 0, 0, 1, 1, 0,  1, 32'h00, 0, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 0,  1, 32'h04, 0, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 0,  0, 32'h08, 1, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 0,  0, 32'h08, 1, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 0,  0, 32'h08, 1, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 0,  0, 32'h08, 1, 32'h0));
        // Decode released: entries drain in order, fetching resumes.
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h08, 1, 32'h0));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h0C, 1, 32'h4));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h10, 1, 32'h8));
        vt.push_back(mkv(0, 0, 0, 1, 1, 1,  1, 32'h14, 1, 32'hC));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst_before) do_reset();
            step(vt[i].redir, vt[i].rpc, vt[i].rdy, vt[i].resp_en, vt[i].idr);
            check_outputs($sformatf("vec%0d", i), vt[i].e_rv, vt[i].e_addr,
                          vt[i].e_idv, vt[i].e_idpc);
        end

        // Memory not ready for 3 cycles: request at 0x4 held stable.
        do_reset();
        step(0, 0, 1, 1, 1); check_outputs("stall0", 1, 32'h0, 0, 32'h0);
        step(0, 0, 0, 1, 1); check_outputs("stall1", 1, 32'h4, 0, 32'h0);
        step(0, 0, 0, 1, 1); check_outputs("stall2", 1, 32'h4, 1, 32'h0);
        step(0, 0, 0, 1, 1); check_outputs("stall3", 1, 32'h4, 0, 32'h0);
        step(0, 0, 1, 1, 1); check_outputs("stall4", 1, 32'h4, 0, 32'h0);
        step(0, 0, 1, 1, 1); check_outputs("stall5", 1, 32'h8, 0, 32'h0);
        step(0, 0, 1, 1, 1); check_outputs("stall6", 1, 32'hC, 1, 32'h4);

        // Redirect to 0x103 with two requests outstanding: both answers dropped.
        do_reset();
        step(0, 0, 1, 0, 1);          check_outputs("redir0", 1, 32'h0,   0, 32'h0);
        step(0, 0, 1, 0, 1);          check_outputs("redir1", 1, 32'h4,   0, 32'h0);
        step(1, 32'h103, 1, 0, 1);    check_outputs("redir2", 0, 32'h8,   0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("redir3", 0, 32'h100, 0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("redir4", 1, 32'h100, 0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("redir5", 1, 32'h104, 0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("redir6", 1, 32'h108, 1, 32'h100);

        // Redirect coinciding with a response and a decode pop.
        do_reset();
        step(0, 0, 1, 1, 1);          check_outputs("rsame0", 1, 32'h0,   0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("rsame1", 1, 32'h4,   0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("rsame2", 1, 32'h8,   1, 32'h0);
        step(1, 32'h200, 1, 1, 1);    check_outputs("rsame3", 0, 32'hC,   1, 32'h4);
        step(0, 0, 1, 1, 1);          check_outputs("rsame4", 1, 32'h200, 0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("rsame5", 1, 32'h204, 0, 32'h0);
        step(0, 0, 1, 1, 1);          check_outputs("rsame6", 1, 32'h208, 1, 32'h200);

        // PC wraps from the top word to zero; redirect low bits are ignored.
        do_reset();
        step(1, 32'hFFFF_FFFF, 1, 0, 1); check_outputs("wrap0", 0, 32'h0,         0, 32'h0);
        step(0, 0, 1, 0, 1);             check_outputs("wrap1", 1, 32'hFFFF_FFFC, 0, 32'h0);
        step(0, 0, 1, 0, 1);             check_outputs("wrap2", 1, 32'h0,         0, 32'h0);
        step(0, 0, 1, 0, 1);             check_outputs("wrap3", 0, 32'h4,         0, 32'h0);

        // Randomized traffic against a program-order model: requests go out at
        // consecutive word addresses from the latest target, and decode sees the
        // same sequence, each with its memory word.
        do_reset();
        model_fetch = 32'h0;
        exp_id      = 32'h0;
        prev_valid  = 1'b0;
        prev_fire   = 1'b0;
        prev_redir  = 1'b0;
        prev_addr   = 32'h0;
        pops        = 0;
        for (int c = 0; c < 4000; c++) begin
            redir = ($urandom_range(0, 24) == 0);
            rpc   = $urandom;
            rdy   = ($urandom_range(0, 3) != 0);
            re    = ($urandom_range(0, 2) != 0);
            idr   = ($urandom_range(0, 3) != 0);
            step(redir, rpc, rdy, re, idr);

            if (prev_redir) check("rand.id_after_redirect", {31'd0, id_valid}, 32'd0);
            if (!id_valid) begin
                check("rand.idle_inst", id_inst, 32'h0000_0013);
                check("rand.idle_pc", id_pc, 32'h0);
            end
            if (prev_valid && !prev_fire && !redir) begin
                check("rand.req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
                check("rand.req_hold_addr", imem_req_addr, prev_addr);
            end
            if (redir) begin
                check("rand.no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
                model_fetch = rpc & 32'hFFFF_FFFC;
                exp_id      = rpc & 32'hFFFF_FFFC;
            end else begin
                if (imem_req_valid && rdy) begin
                    check("rand.req_addr", imem_req_addr, model_fetch);
                    model_fetch = model_fetch + 32'd4;
                end
                if (id_valid && idr) begin
                    check("rand.id_pc", id_pc, exp_id);
                    check("rand.id_inst", id_inst, memw(exp_id));
                    exp_id = exp_id + 32'd4;
                    pops++;
                end
            end
            prev_valid = imem_req_valid;
            prev_fire  = imem_req_valid && rdy;
            prev_addr  = imem_req_addr;
            prev_redir = redir;
        end
        check("rand.progress", {31'd0, (pops > 300)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
